// File: rtl/puf_pkg.sv
// Shared definitions for the PUF scan-window blocks (counter and response collector).
package puf_pkg;

  localparam int DEF_RESP_WIDTH  = 64;
  localparam int DEF_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } puf_state_t;

endpackage

// File: rtl/puf_shift_capture.sv
// Serial response shift register with a saturating sampled-bit counter and a
// sticky overflow flag; sequenced by the collector FSM through i_start/i_shift.
module puf_shift_capture #(
  parameter int RESP_WIDTH  = 64,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_shift,
  input  logic                   i_bit,
  output logic [RESP_WIDTH-1:0]  o_shreg,
  output logic [COUNT_WIDTH-1:0] o_bit_count,
  output logic                   o_overflow
);

  localparam logic [COUNT_WIDTH:0] LP_FULL = (COUNT_WIDTH+1)'(RESP_WIDTH);

  logic [RESP_WIDTH-1:0]  r_shreg;
  logic [COUNT_WIDTH-1:0] r_bit_count;
  logic                   r_overflow;
  logic                   w_full;

  // Register already holds RESP_WIDTH bits, so the next sample pushes one out.
  assign w_full = ({1'b0, r_bit_count} >= LP_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg     <= '0;
      r_bit_count <= '0;
      r_overflow  <= 1'b0;
    end else if (i_start) begin
      r_shreg     <= {{(RESP_WIDTH-1){1'b0}}, i_bit};
      r_bit_count <= COUNT_WIDTH'(1);
      r_overflow  <= 1'b0;
    end else if (i_shift) begin
      r_shreg <= {r_shreg[RESP_WIDTH-2:0], i_bit};
      if (r_bit_count != '1) begin
        r_bit_count <= r_bit_count + COUNT_WIDTH'(1);
      end
      if (w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_shreg     = r_shreg;
  assign o_bit_count = r_bit_count;
  assign o_overflow  = r_overflow;

endmodule

// File: rtl/puf_scan_response_collector.sv
// Collects the serial PUF response over a scan window and offers the assembled
// word on a valid/ready port; windows arriving while a word is held are dropped.
module puf_scan_response_collector
  import puf_pkg::*;
#(
  parameter int RESP_WIDTH  = DEF_RESP_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   scan_enable,
  input  logic                   scan_in,
  input  logic                   count_done,
  input  logic                   resp_ready,
  output logic [RESP_WIDTH-1:0]  response,
  output logic                   resp_valid,
  output logic [COUNT_WIDTH-1:0] bit_count,
  output logic                   overflow,
  output logic                   busy,
  output logic                   capture_dropped,
  output logic [1:0]             dbg_state
);

  // Handshake: resp_valid rises the cycle after count_done and stays high with
  // stable data until a cycle where resp_valid && resp_ready; that cycle is the
  // transfer and resp_valid drops on the following cycle.

  puf_state_t r_state;
  puf_state_t w_next_state;
  logic       r_scan_en_d;
  logic       r_block;
  logic       r_dropped;
  logic       w_start;
  logic       w_shift;

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A window already underway when we came back from HOLD is partial; skip it.
        if (scan_enable && !r_block) begin
          w_start      = 1'b1;
          w_next_state = count_done ? ST_HOLD : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift = scan_enable;
        if (count_done) begin
          w_next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (resp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_scan_en_d <= 1'b0;
      r_block     <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_scan_en_d <= scan_enable;
      r_block     <= scan_enable && ((r_state == ST_HOLD) || r_block);
      r_dropped   <= (r_state == ST_HOLD) && scan_enable && !r_scan_en_d;
    end
  end

  puf_shift_capture #(
    .RESP_WIDTH  (RESP_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_capture (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_start),
    .i_shift     (w_shift),
    .i_bit       (scan_in),
    .o_shreg     (response),
    .o_bit_count (bit_count),
    .o_overflow  (overflow)
  );

  assign resp_valid      = (r_state == ST_HOLD);
  assign busy            = (r_state != ST_IDLE);
  assign capture_dropped = r_dropped;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_puf_scan_response_collector.sv
// Directed bench for puf_scan_response_collector with a window-level reference
// model checked every cycle, plus literal expectations for each scenario.
module tb_puf_scan_response_collector;

  localparam int W  = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scan_enable = 1'b0;
  logic          scan_in = 1'b0;
  logic          count_done = 1'b0;
  logic          resp_ready = 1'b0;
  logic [W-1:0]  response;
  logic          resp_valid;
  logic [CW-1:0] bit_count;
  logic          overflow;
  logic          busy;
  logic          capture_dropped;
  logic [1:0]    dbg_state;

  puf_scan_response_collector #(.RESP_WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .scan_enable     (scan_enable),
    .scan_in         (scan_in),
    .count_done      (count_done),
    .resp_ready      (resp_ready),
    .response        (response),
    .resp_valid      (resp_valid),
    .bit_count       (bit_count),
    .overflow        (overflow),
    .busy            (busy),
    .capture_dropped (capture_dropped),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (window level) ----------------
  bit           m_collect = 1'b0;
  bit           m_hold    = 1'b0;
  bit           m_block   = 1'b0;
  bit           m_prev_en = 1'b0;
  bit           m_drop    = 1'b0;
  bit           m_known   = 1'b1;
  logic [W-1:0] m_resp    = '0;
  int           m_cnt     = 0;
  bit           m_ovf     = 1'b0;
  bit           m_bits[$];

  task automatic model_reset();
    m_collect = 1'b0;
    m_hold    = 1'b0;
    m_block   = 1'b0;
    m_prev_en = 1'b0;
    m_drop    = 1'b0;
    m_known   = 1'b1;
    m_resp    = '0;
    m_cnt     = 0;
    m_ovf     = 1'b0;
    m_bits.delete();
  endtask

  task automatic finish_window();
    int n;
    int first;
    n = m_bits.size();
    first = (n > W) ? n - W : 0;
    m_resp = '0;
    for (int i = first; i < n; i++) m_resp = {m_resp[W-2:0], m_bits[i]};
    m_cnt   = (n > 65535) ? 65535 : n;
    m_ovf   = (n > W);
    m_hold  = 1'b1;
    m_known = 1'b1;
  endtask

  task automatic model_step();
    bit was_hold;
    was_hold = m_hold;
    m_drop   = m_hold && scan_enable && !m_prev_en;
    if (m_hold) begin
      if (resp_ready) m_hold = 1'b0;
    end else if (m_collect) begin
      if (scan_enable) m_bits.push_back(scan_in);
      if (count_done) begin
        m_collect = 1'b0;
        finish_window();
      end
    end else if (scan_enable && !m_block) begin
      m_bits.delete();
      m_bits.push_back(scan_in);
      m_known = 1'b0;
      if (count_done) finish_window();
      else m_collect = 1'b1;
    end
    // A window seen while holding stays off-limits until scan_enable drops.
    m_block   = scan_enable && (was_hold || m_block);
    m_prev_en = scan_enable;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (run_chk && rst_n) begin
      chk("resp_valid", 64'(resp_valid), 64'(m_hold));
      chk("busy", 64'(busy), 64'(m_hold || m_collect));
      chk("capture_dropped", 64'(capture_dropped), 64'(m_drop));
      chk("dbg_state", 64'(dbg_state), m_hold ? 64'd2 : (m_collect ? 64'd1 : 64'd0));
      if (m_known) begin
        chk("response", response, m_resp);
        chk("bit_count", 64'(bit_count), 64'(m_cnt));
        chk("overflow", 64'(overflow), 64'(m_ovf));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic en, input logic b, input logic d, input logic r);
    @(negedge clk);
    scan_enable = en;
    scan_in     = b;
    count_done  = d;
    resp_ready  = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- directed stimulus ----------------
  logic [7:0] v_basic;
  logic [3:0] v_drop;
  logic [5:0] v_pause;

  initial begin
    v_basic = 8'b1011_0010;
    v_drop  = 4'b1001;
    v_pause = 6'b110101;

    repeat (2) @(negedge clk);
    chk("rst_response", response, 64'h0);
    chk("rst_bit_count", 64'(bit_count), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_capture_dropped", 64'(capture_dropped), 64'h0);
    #2 rst_n = 1'b1;
    run_chk = 1'b1;
    idle(2);

    // Basic 8-bit window, then backpressure for 5 cycles.
    for (int i = 7; i >= 0; i--) drive(1'b1, v_basic[i], 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("basic_valid_latency", 64'(resp_valid), 64'h1);
    chk("basic_response", response, 64'h0000_0000_0000_00B2);
    chk("basic_bit_count", 64'(bit_count), 64'd8);
    chk("basic_overflow", 64'(overflow), 64'h0);
    chk("model_basic_response", m_resp, 64'h0000_0000_0000_00B2);
    idle(4);
    chk("bp_still_valid", 64'(resp_valid), 64'h1);
    chk("bp_response", response, 64'h0000_0000_0000_00B2);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("hs_valid_dropped", 64'(resp_valid), 64'h0);
    chk("hs_busy", 64'(busy), 64'h0);
    idle(1);
    chk("hs_busy_later", 64'(busy), 64'h0);

    // Overflow: 70 bits, bit i = i[0], last one coincident with count_done.
    for (int i = 0; i < 69; i++) drive(1'b1, i[0], 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    chk("ovf_response", response, 64'h5555_5555_5555_5555);
    chk("ovf_bit_count", 64'(bit_count), 64'd70);
    chk("ovf_overflow", 64'(overflow), 64'h1);
    chk("model_ovf_response", m_resp, 64'h5555_5555_5555_5555);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Dropped window; handshake lands while that window is still active.
    for (int i = 3; i >= 0; i--) drive(1'b1, v_drop[i], 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("drop_first_valid", 64'(resp_valid), 64'h1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("drop_pulse_high", 64'(capture_dropped), 64'h1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk("drop_pulse_low", 64'(capture_dropped), 64'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("drop_after_hs_valid", 64'(resp_valid), 64'h0);
    chk("drop_partial_not_started", 64'(busy), 64'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("drop_idle_busy", 64'(busy), 64'h0);
    chk("drop_keep_response", response, 64'h9);
    chk("drop_keep_count", 64'(bit_count), 64'd4);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("lone_done_ignored", 64'(busy), 64'h0);

    // Pause of 3 cycles mid-window, final bit together with count_done.
    drive(1'b1, v_pause[5], 1'b0, 1'b0);
    drive(1'b1, v_pause[4], 1'b0, 1'b0);
    drive(1'b1, v_pause[3], 1'b0, 1'b0);
    idle(3);
    chk("pause_busy", 64'(busy), 64'h1);
    drive(1'b1, v_pause[2], 1'b0, 1'b0);
    drive(1'b1, v_pause[1], 1'b0, 1'b0);
    drive(1'b1, v_pause[0], 1'b1, 1'b0);
    idle(1);
    chk("pause_response", response, 64'h35);
    chk("pause_bit_count", 64'(bit_count), 64'd6);
    chk("pause_overflow", 64'(overflow), 64'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Reset in the middle of a window, then a fresh 4-bit window.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    scan_enable = 1'b0;
    scan_in     = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_response", response, 64'h0);
    chk("midrst_bit_count", 64'(bit_count), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_resp_valid", 64'(resp_valid), 64'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    chk("fresh_response", response, 64'hF);
    chk("fresh_bit_count", 64'(bit_count), 64'd4);
    chk("fresh_valid", 64'(resp_valid), 64'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
